// File: rtl/frame_serializer_pkg.sv
// Shared types, default sizes and index helpers for the frame serializer and the FFT stages.
package frame_serializer_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int NP_DEFAULT         = 1024;
    localparam int NB_SAMPLES_DEFAULT = 16;
    localparam int NB_INDEX           = $clog2(NP_DEFAULT);

    // Reverses the low nbits of value; bits above nbits come back as zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int nbits);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                result[i] = value[nbits - 1 - i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// Frame-in / sample-out bus of the frame serializer; master is the serializer side.
interface frame_serializer_if
    import frame_serializer_pkg::*;
#(
    parameter int  NP         = NP_DEFAULT,
    parameter int  NB_SAMPLES = NB_SAMPLES_DEFAULT,
    localparam int NB_IDX     = $clog2(NP)
);

    logic                       enable;
    logic                       clear_ovr;
    logic [NB_SAMPLES*NP-1:0]   frame;
    logic                       frame_valid;
    logic                       ready;
    logic [NB_SAMPLES-1:0]      sample;
    logic                       valid;
    logic                       last;
    logic [NB_IDX-1:0]          index;
    logic                       busy;
    logic                       overrun;

    modport master (
        input  enable, clear_ovr, frame, frame_valid, ready,
        output sample, valid, last, index, busy, overrun
    );

    modport slave (
        output enable, clear_ovr, frame, frame_valid, ready,
        input  sample, valid, last, index, busy, overrun
    );

endinterface

// File: rtl/frame_serializer_index_gen.sv
// Transfer counter and readout address mapping. Defining FRAME_SERIALIZER_BITREV_EN
// selects bit-reversed readout order; otherwise elements go out in natural order.
module frame_index_gen
    import frame_serializer_pkg::*;
#(
    parameter int  NP     = NP_DEFAULT,
    localparam int NB_IDX = $clog2(NP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              advance,
    output logic [NB_IDX-1:0] addr,
    output logic [NB_IDX-1:0] next_addr,
    output logic              terminal
);

    logic [NB_IDX-1:0] cnt;
    logic [NB_IDX-1:0] cnt_inc;

    // cnt wraps to 0 after the final transfer, so next_addr then points at element addr(0).
    assign cnt_inc  = cnt + NB_IDX'(1);
    assign terminal = (cnt == NB_IDX'(NP - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (enable) begin
            if (clear) begin
                cnt <= '0;
            end else if (advance) begin
                cnt <= cnt_inc;
            end
        end
    end

`ifdef FRAME_SERIALIZER_BITREV_EN
    assign addr      = NB_IDX'(bit_reverse(32'(cnt), NB_IDX));
    assign next_addr = NB_IDX'(bit_reverse(32'(cnt_inc), NB_IDX));
`else
    assign addr      = cnt;
    assign next_addr = cnt_inc;
`endif

endmodule

// File: rtl/frame_serializer.sv
// Captures one packed frame and streams it one sample per cycle over valid/ready.
// Readout order is set by FRAME_SERIALIZER_BITREV_EN inside frame_index_gen.
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int  NP         = NP_DEFAULT,
    parameter int  NB_SAMPLES = NB_SAMPLES_DEFAULT,
    localparam int NB_IDX     = $clog2(NP)
) (
    input  logic                clk,
    input  logic                rst,
    frame_serializer_if.master  bus
);

    state_t                 state;
    logic [NB_SAMPLES-1:0]  buffer [NP];
    logic [NB_SAMPLES-1:0]  sample_q;
    logic                   overrun_q;

    logic [NB_IDX-1:0]      addr;
    logic [NB_IDX-1:0]      next_addr;
    logic                   terminal;

    logic                   stream_valid;
    logic                   xfer;
    logic                   last_xfer;
    logic                   capture;
    logic                   drop;

    assign stream_valid = (state == STREAM) && bus.enable;
    assign xfer         = stream_valid && bus.ready;
    assign last_xfer    = xfer && terminal;
    // A frame arriving with the final transfer replaces the old one without a bubble.
    assign capture      = bus.enable && bus.frame_valid && ((state == IDLE) || last_xfer);
    assign drop         = bus.enable && bus.frame_valid && (state == STREAM) && !last_xfer;

    frame_index_gen #(.NP(NP)) u_index_gen (
        .clk       (clk),
        .rst       (rst),
        .enable    (bus.enable),
        .clear     (capture),
        .advance   (xfer),
        .addr      (addr),
        .next_addr (next_addr),
        .terminal  (terminal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (bus.enable) begin
            if (capture) begin
                state <= STREAM;
            end else if (last_xfer) begin
                state <= IDLE;
            end
        end
    end

    // NOTE: the buffer is reset because a reset must leave no trace of a discarded frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NP; k++) begin
                buffer[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < NP; k++) begin
                buffer[k] <= bus.frame[k*NB_SAMPLES +: NB_SAMPLES];
            end
        end
    end

    // o_sample is registered one step ahead; addr(0) is element 0 in both readout orders.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= '0;
        end else if (capture) begin
            sample_q <= bus.frame[NB_SAMPLES-1:0];
        end else if (xfer) begin
            sample_q <= buffer[next_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (bus.enable && bus.clear_ovr) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.sample  = sample_q;
    assign bus.valid   = stream_valid;
    assign bus.last    = last_xfer;
    assign bus.index   = addr;
    assign bus.busy    = (state == STREAM);
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer at NP=8, NB_SAMPLES=16; follows FRAME_SERIALIZER_BITREV_EN.
module tb_frame_serializer;

    localparam int NP         = 8;
    localparam int NB_SAMPLES = 16;

    typedef struct {
        logic ready;
        int   k;
        logic last;
    } bp_vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   last_count;
    bp_vec_t bp [14];

    frame_serializer_if #(.NP(NP), .NB_SAMPLES(NB_SAMPLES)) bus ();

    frame_serializer #(.NP(NP), .NB_SAMPLES(NB_SAMPLES)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Element position of the k-th transfer, written out by hand.
    function automatic int exp_addr(input int k);
`ifdef FRAME_SERIALIZER_BITREV_EN
        case (k)
            0: return 0;
            1: return 4;
            2: return 2;
            3: return 6;
            4: return 1;
            5: return 5;
            6: return 3;
            default: return 7;
        endcase
`else
        return k;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_frame(input logic [15:0] base);
        for (int k = 0; k < NP; k++) begin
            bus.frame[k*NB_SAMPLES +: NB_SAMPLES] = base + 16'(k);
        end
    endtask

    task automatic send_frame(input logic [15:0] base);
        set_frame(base);
        bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [15:0] base, input int k, input logic exp_last);
        #1;
        check($sformatf("%s_k%0d_valid", tag, k), 32'(bus.valid), 32'd1);
        check($sformatf("%s_k%0d_sample", tag, k), 32'(bus.sample), 32'(base + 16'(exp_addr(k))));
        check($sformatf("%s_k%0d_index", tag, k), 32'(bus.index), 32'(exp_addr(k)));
        check($sformatf("%s_k%0d_last", tag, k), 32'(bus.last), 32'(exp_last));
        check($sformatf("%s_k%0d_busy", tag, k), 32'(bus.busy), 32'd1);
    endtask

    task automatic stream(input string tag, input logic [15:0] base, input int from, input int upto);
        for (int k = from; k <= upto; k++) begin
            check_beat(tag, base, k, k == NP - 1);
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        #1;
        check({tag, "_valid"}, 32'(bus.valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_last"}, 32'(bus.last), 32'd0);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        bus.enable      = 1'b1;
        bus.clear_ovr   = 1'b0;
        bus.frame       = '0;
        bus.frame_valid = 1'b0;
        bus.ready       = 1'b0;

        // Backpressure vectors: ready pattern and the transfer index expected on the bus.
        bp[0]  = '{1'b1, 0, 1'b0};
        bp[1]  = '{1'b0, 1, 1'b0};
        bp[2]  = '{1'b0, 1, 1'b0};
        bp[3]  = '{1'b1, 1, 1'b0};
        bp[4]  = '{1'b0, 2, 1'b0};
        bp[5]  = '{1'b1, 2, 1'b0};
        bp[6]  = '{1'b1, 3, 1'b0};
        bp[7]  = '{1'b0, 4, 1'b0};
        bp[8]  = '{1'b1, 4, 1'b0};
        bp[9]  = '{1'b1, 5, 1'b0};
        bp[10] = '{1'b0, 6, 1'b0};
        bp[11] = '{1'b1, 6, 1'b0};
        bp[12] = '{1'b0, 7, 1'b0};
        bp[13] = '{1'b1, 7, 1'b1};

        tick();
        #1;
        check("reset_sample", 32'(bus.sample), 32'd0);
        check("reset_index", 32'(bus.index), 32'd0);
        check("reset_overrun", 32'(bus.overrun), 32'd0);
        check_idle("reset");
        tick();
        rst = 1'b0;
        tick();

        // Basic stream, natural handshake.
        bus.ready = 1'b1;
        set_frame(16'h0100);
        bus.frame_valid = 1'b1;
        #1;
        check("basic_pre_valid", 32'(bus.valid), 32'd0);
        tick();
        bus.frame_valid = 1'b0;
        stream("basic", 16'h0100, 0, NP - 1);
        check_idle("basic_end");

        // Backpressure from the table.
        send_frame(16'h0100);
        last_count = 0;
        for (int i = 0; i < 14; i++) begin
            bus.ready = bp[i].ready;
            check_beat($sformatf("bp%0d", i), 16'h0100, bp[i].k, bp[i].last);
            if (bus.last) last_count++;
            tick();
        end
        check("bp_last_count", 32'(last_count), 32'd1);
        check_idle("bp_end");

        // Back-to-back: next frame strobed together with the last transfer.
        bus.ready = 1'b1;
        send_frame(16'h0100);
        stream("b2b_a", 16'h0100, 0, NP - 2);
        set_frame(16'h0200);
        bus.frame_valid = 1'b1;
        check_beat("b2b_a", 16'h0100, NP - 1, 1'b1);
        tick();
        bus.frame_valid = 1'b0;
        stream("b2b_b", 16'h0200, 0, NP - 1);
        #1;
        check("b2b_overrun", 32'(bus.overrun), 32'd0);
        check_idle("b2b_end");

        // Overrun: new frame at cnt=3 is dropped, current frame continues untouched.
        send_frame(16'h0100);
        stream("ovr", 16'h0100, 0, 2);
        set_frame(16'h0300);
        bus.frame_valid = 1'b1;
        check_beat("ovr", 16'h0100, 3, 1'b0);
        tick();
        bus.frame_valid = 1'b0;
        #1;
        check("ovr_set", 32'(bus.overrun), 32'd1);
        stream("ovr", 16'h0100, 4, NP - 1);
        check_idle("ovr_end");
        check("ovr_sticky", 32'(bus.overrun), 32'd1);
        bus.clear_ovr = 1'b1;
        tick();
        bus.clear_ovr = 1'b0;
        #1;
        check("ovr_cleared", 32'(bus.overrun), 32'd0);

        // Set and clear in the same cycle: set wins.
        send_frame(16'h0500);
        stream("setclr", 16'h0500, 0, 0);
        set_frame(16'h0600);
        bus.frame_valid = 1'b1;
        bus.clear_ovr   = 1'b1;
        check_beat("setclr", 16'h0500, 1, 1'b0);
        tick();
        bus.frame_valid = 1'b0;
        bus.clear_ovr   = 1'b0;
        #1;
        check("setclr_overrun", 32'(bus.overrun), 32'd1);
        stream("setclr", 16'h0500, 2, NP - 1);
        bus.clear_ovr = 1'b1;
        tick();
        bus.clear_ovr = 1'b0;
        #1;
        check("setclr_cleared", 32'(bus.overrun), 32'd0);

        // Enable freeze at cnt=2 for five cycles.
        send_frame(16'h0100);
        stream("en", 16'h0100, 0, 1);
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("en_off%0d_valid", i), 32'(bus.valid), 32'd0);
            check($sformatf("en_off%0d_last", i), 32'(bus.last), 32'd0);
            check($sformatf("en_off%0d_index", i), 32'(bus.index), 32'(exp_addr(2)));
            check($sformatf("en_off%0d_sample", i), 32'(bus.sample), 32'(16'h0100 + 16'(exp_addr(2))));
            check($sformatf("en_off%0d_busy", i), 32'(bus.busy), 32'd1);
            tick();
        end
        bus.enable = 1'b1;
        stream("en", 16'h0100, 2, NP - 1);
        check_idle("en_end");

        // Reset mid-frame at cnt=5, then a fresh frame from element 0.
        send_frame(16'h0100);
        stream("rst", 16'h0100, 0, 4);
        rst = 1'b1;
        tick();
        #1;
        check("midrst_sample", 32'(bus.sample), 32'd0);
        check("midrst_index", 32'(bus.index), 32'd0);
        check("midrst_overrun", 32'(bus.overrun), 32'd0);
        check_idle("midrst");
        rst = 1'b0;
        tick();
        send_frame(16'h0400);
        stream("fresh", 16'h0400, 0, NP - 1);
        check_idle("fresh_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
# frame_serializer

- Downstream neighbour of the input windowing stage.
- Captures one windowed frame (NP packed samples, qualified by the window stage's valid pulse) into a holding buffer.
- Streams the frame to the FFT one sample per cycle under a valid/ready handshake, with an optional bit-reversed readout order for a radix-2 DIT core.
- Flags frames that arrive while a previous frame is still streaming.

## Interface
Parameters:
- NP, 1024, samples per frame; power of two, ≥ 4
- NB_SAMPLES, 16, bits per sample (matches the window stage's NB_OUTPUT)

Ports:
- clock  in  1  system clock; all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  module enable; low freezes all state
- i_frame  in  NB_SAMPLES*NP  packed frame; element k = i_frame[(k+1)*NB_SAMPLES-1 -: NB_SAMPLES]
- i_valid  in  1  one-cycle frame strobe from the window stage
- i_ready  in  1  downstream ready
- i_clear_ovr  in  1  synchronous clear of o_overrun
- o_sample  out  NB_SAMPLES  current sample, signed
- o_valid  out  1  o_sample valid
- o_last  out  1  high with the final sample of a frame
- o_index  out  $clog2(NP)  frame element index of o_sample
- o_busy  out  1  frame held and not fully transferred
- o_overrun  out  1  sticky dropped-frame flag

## Operation
State machine:
- Two states, IDLE and STREAM. A buffer of NP registers and a transfer counter cnt (0..NP-1).
- Inputs are ignored when i_enable is low, except i_reset.
- IDLE, i_valid=1: latch the whole i_frame into the buffer, cnt←0, go to STREAM.
- STREAM: o_valid=1 while i_enable=1. A transfer occurs when o_valid && i_ready; each transfer increments cnt.
- Transfer with cnt==NP-1: o_last=1 for that cycle. Next state is IDLE, unless i_valid is high in the same cycle.
- Simultaneous last transfer and i_valid: capture the new frame, cnt←0, stay in STREAM. There is no bubble and no overrun.
- i_valid in STREAM without a last transfer: drop the new frame; buffer and cnt are unchanged; o_overrun←1.
- o_overrun clears only on reset or i_clear_ovr=1. If set and clear coincide, set wins.

Outputs:
- o_valid = (state==STREAM) && i_enable. When low, o_sample, o_index, o_last and cnt hold their values.
- Once o_valid is high, o_sample and o_index are stable until the transfer completes.
- o_index = addr(cnt); o_sample = buffer[o_index]; o_busy = (state==STREAM).
- Samples pass through unmodified. There is no arithmetic; the width is preserved.

Reset (mid-frame included): state IDLE, cnt 0, buffer cleared. The partially streamed frame is discarded and no o_last is issued. Reset values: o_sample 0, o_valid 0, o_last 0, o_index 0, o_busy 0, o_overrun 0.

## Timing
- Capture on the edge where i_valid=1. o_valid rises the following cycle with element addr(0): latency 1 cycle.
- With i_ready held high, a frame streams in exactly NP consecutive cycles.
- Back-to-back frames every NP cycles sustain full throughput.
- o_sample, o_index and o_busy are driven from registers only.
- o_valid and o_last depend combinationally on state, cnt and i_enable. o_last additionally depends on i_ready, since it is asserted only with a transfer.
- No combinational path exists from i_frame to any output.
- The window stage's minimum frame spacing is L cycles. L < NP with a stalled downstream therefore produces overruns by design.

## Configuration
- FRAME_SERIALIZER_BITREV_EN defined: addr(cnt) = bit-reverse of cnt over $clog2(NP) bits. Example, NP=8: output order 0,4,2,6,1,5,3,7. o_last still marks the NP-th transfer.
- Undefined: addr(cnt)=cnt, natural order 0..NP-1.
- Handshake, latency and all other behaviour are identical in both builds.

## Structure
Shared package:
- state enum (IDLE, STREAM)
- localparam NB_INDEX = $clog2(NP)
- bit-reverse function, reused by the FFT stages

Sub-module:
- frame_index_gen: the cnt register, increment/clear on transfer or capture, terminal-count flag and addr mapping. The macro is applied only inside this sub-module.
- The top level holds the buffer, the FSM and the overrun flag.

## Test plan
Run with NP=8 and NB_SAMPLES=16.

- Basic stream: element k = 0x0100+k, i_valid pulse, i_ready=1 → o_valid from the next cycle for 8 cycles; o_sample 0x0100..0x0107; o_index 0..7; o_last only on 0x0107; then o_busy=0.
- Backpressure: i_ready toggled 1,0,0,1,... → each sample is held stable while stalled. No skips or repeats. o_last appears exactly once.
- Back-to-back: second frame (0x0200+k) with i_valid in the cycle of the last transfer → 0x0200 appears in the very next cycle; o_overrun stays 0.
- Overrun: i_valid at cnt=3 → the rest of frame 1 is unchanged (0x0104..0x0107), frame 2 is dropped, o_overrun=1 until i_clear_ovr. Set and clear in the same cycle leaves o_overrun=1.
- Enable and reset: i_enable=0 at cnt=2 for 5 cycles → o_valid=0 and nothing advances; resuming continues at 0x0102. Asserting i_reset at cnt=5 → all outputs 0 next, and a fresh frame starts at element 0.
- Bit-reverse build (FRAME_SERIALIZER_BITREV_EN): with the basic-stream frame, o_sample = 0x0100,0x0104,0x0102,0x0106,0x0101,0x0105,0x0103,0x0107.
